// File: rtl/des_key_sched.sv
// Time-multiplexed DES key schedule: PC-1 on key load, per-round C/D rotation, PC-2 on output.
// Emits one subkey per sk handshake, K1..KN (encrypt) or KN..K1 (decrypt); first subkey one cycle after key accept.
module des_key_sched #(
  parameter int ROUNDS       = 16,
  parameter bit PARITY_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        abort,
  output logic [47:0] sk_out,
  output logic [3:0]  sk_round,
  output logic        sk_last,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic        busy,
  output logic        parity_err
);

  typedef enum logic {IDLE, GEN} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  // Table entries are FIPS 46-3 bit numbers (1 = MSB of the source vector).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = k[64-PC1[i]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[47-i] = cd[56-PC2[i]];
    end
    return r;
  endfunction

  // Shift amount for 0-based round index r: 1 for rounds 1, 2, 9, 16, else 2.
  function automatic logic shift_two(input logic [4:0] r);
    logic two;
    case (r)
      5'd0, 5'd1, 5'd8, 5'd15: two = 1'b0;
      default:                 two = (r < 5'd16);
    endcase
    return two;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic parity_bad(input logic [63:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bad = bad | ~^k[8*b +: 8];
    end
    return bad;
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, d_q;
  logic [3:0]  round_q;
  logic        dec_q;
  logic        parity_q;
  logic        last_i;
  logic        take_key;
  logic        advance;
  logic [55:0] cd0;
  logic [4:0]  round_nxt;

  assign cd0       = pc1(key_in);
  assign round_nxt = {1'b0, round_q} + 5'd1;
  assign last_i    = (!dec_q && round_q == LAST_ROUND) || (dec_q && round_q == 4'd0);

  assign take_key = (state_q == IDLE) && key_valid;
  assign advance  = (state_q == GEN) && !abort && sk_ready && !last_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort outranks the subkey handshake, so the presented subkey is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (key_valid) state_d = GEN;
      GEN: begin
        if (abort)                  state_d = IDLE;
        else if (sk_ready && last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decrypt starts from the unrotated C0/D0: the 16 shifts total 28, so C16/D16 == C0/D0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q      <= '0;
      d_q      <= '0;
      round_q  <= '0;
      dec_q    <= 1'b0;
      parity_q <= 1'b0;
    end else if (take_key) begin
      if (decrypt) begin
        c_q     <= cd0[55:28];
        d_q     <= cd0[27:0];
        round_q <= LAST_ROUND;
      end else begin
        c_q     <= rotl(cd0[55:28], shift_two(5'd0));
        d_q     <= rotl(cd0[27:0], shift_two(5'd0));
        round_q <= 4'd0;
      end
      dec_q    <= decrypt;
      parity_q <= PARITY_CHECK ? parity_bad(key_in) : 1'b0;
    end else if (advance) begin
      if (dec_q) begin
        c_q     <= rotr(c_q, shift_two({1'b0, round_q}));
        d_q     <= rotr(d_q, shift_two({1'b0, round_q}));
        round_q <= round_q - 4'd1;
      end else begin
        c_q     <= rotl(c_q, shift_two(round_nxt));
        d_q     <= rotl(d_q, shift_two(round_nxt));
        round_q <= round_nxt[3:0];
      end
    end
  end

  // key_ready is held low while reset is asserted so no key is offered into a resetting block.
  assign key_ready  = (state_q == IDLE) && rst_n;
  assign sk_valid   = (state_q == GEN);
  assign busy       = (state_q == GEN);
  assign sk_last    = (state_q == GEN) && last_i;
  assign sk_out     = pc2({c_q, d_q});
  assign sk_round   = round_q;
  assign parity_err = parity_q;

endmodule

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
- Sequential DES key-schedule generator: accepts one 64-bit key and streams the round subkeys K1..KN (encrypt) or KN..K1 (decrypt) over a valid/ready interface, one per handshake.
- Internally: PC-1, per-round C/D rotation per the FIPS 46-3 shift table, and PC-2 compression.
- Sits between the key-load path and the round datapath. Replaces per-round static PC-2 wiring with a single time-multiplexed generator.

Parameters:
- ROUNDS, 16, number of subkeys emitted per key (1..16); uses the first ROUNDS entries of the shift table.
- PARITY_CHECK, 1, 1 = check odd parity of each key byte and report on parity_err; 0 = parity_err tied 0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  64  DES key; FIPS bit 1 = key_in[63]; parity bits are key_in[56], key_in[48], ..., key_in[0].
- decrypt  in  1  sampled with the key; 1 = emit subkeys in reverse order.
- key_valid  in  1  key_in/decrypt valid.
- key_ready  out  1  block can accept a key.
- abort  in  1  synchronous; discard the current key schedule.
- sk_out  out  48  current subkey; FIPS bit 1 = sk_out[47].
- sk_round  out  4  index of the subkey on sk_out: n-1 for Kn.
- sk_last  out  1  sk_out is the final subkey of this key.
- sk_valid  out  1  sk_out valid.
- sk_ready  in  1  consumer accepts the subkey.
- busy  out  1  schedule in progress.
- parity_err  out  1  registered; the last accepted key had a byte with even parity.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; C/D registers, counter and sk_round = 0; sk_valid, sk_last, busy, parity_err = 0; key_ready = 1 after release.
- States: IDLE, GEN.
- IDLE: key_ready=1, sk_valid=0. On key_valid:
  - Latch C0/D0 = PC-1(key_in).
  - Encrypt: C/D registers = C0/D0 rotated left by shift[1]; round = 0.
  - Decrypt: C/D registers = C0/D0 unrotated (valid because the total shift over 16 rounds is 28); round = ROUNDS-1.
  - Latch the mode, update parity_err, go to GEN.
- GEN: key_ready=0, busy=1, sk_valid=1.
  - sk_out = PC-2(C,D), combinational from the registers. sk_round = round.
  - First sk_valid is the cycle after the key handshake (latency 1).
  - sk_out/sk_round/sk_last hold stable while sk_valid & !sk_ready.
- On sk_valid & sk_ready:
  - Not last, encrypt: rotate C and D left by shift[round+2] (1-indexed table); round+1.
  - Not last, decrypt: rotate C and D right by shift[round+1]; round-1.
  - Last: go to IDLE; key_ready=1 the next cycle.
- sk_last = (encrypt & round==ROUNDS-1) | (decrypt & round==0).
- Shift table (rounds 1..16): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Rotations are applied independently to the 28-bit C and D halves.
- Decrypt order is exact only for ROUNDS=16. With ROUNDS<16 and decrypt=1, the block still emits ROUNDS subkeys starting at K16; this configuration is unsupported and no error is flagged.
- parity_err: updated only on key acceptance; holds until the next acceptance or reset. Keys with bad parity are still processed.
- abort=1 in GEN: next cycle IDLE, sk_valid=0, busy=0; the subkey presented that cycle is not consumed. abort=1 in IDLE: ignored. abort has priority over the sk handshake.
- key_valid while busy: not accepted (key_ready=0); the producer must hold the key.
- A back-to-back key can be accepted the cycle after the last handshake, giving one idle bubble on sk_valid.
- rst_n asserted mid-GEN: immediate return to reset state; the partial schedule is lost.

Test Plan:
- Key 133457799BBCDFF1, decrypt=0, sk_ready=1 constantly:
  - K1 (sk_round=0) = 1B02EFFC7072, K16 (sk_round=15, sk_last=1) = CB3D8B0E17F5.
  - 16 consecutive sk_valid cycles; parity_err=0.
- Same key, decrypt=1: first subkey CB3D8B0E17F5 with sk_round=15; last subkey 1B02EFFC7072 with sk_round=0 and sk_last=1.
- Backpressure: sk_ready toggles 1,0,0,1...
  - sk_out/sk_round stable across the stall cycles.
  - Exactly 16 handshakes; the sequence matches the no-stall run.
- Key 133457799BBCDFF0: parity_err=1 after acceptance; subkeys are still generated.
- abort asserted at sk_round=5: next cycle sk_valid=0, key_ready=1; a new key then yields K1 = 1B02EFFC7072 again.
- rst_n pulsed low mid-schedule: all outputs 0 asynchronously, key_ready=1 after release; key_valid held during busy is accepted only after the last handshake.
